vga_fb_arbiter: RTL and testbench



---
 rtl/vga_fb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Frame-buffer arbiter: display scan-out reads win, host uses the leftover cycles.
// Optional page flipping is enabled by defining FBA_PAGE_FLIP_EN.
module vga_fb_arbiter #(
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE       = 480,
  parameter int WORDS_PER_LINE = 80,
  parameter int ADDR_W         = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              pix_on,
  output logic              pix_de,
  input  logic              flip_req,
  output logic              flip_done
);

  localparam int OW = ADDR_W - 1;

  typedef enum logic {
    IDLE,
    ACK
  } state_t;

  state_t state_q;
  state_t state_d;

  logic          h_act;
  logic          v_act;
  logic          disp_slot;
  logic          grant;
  logic          page;
  logic [OW-1:0] line_base;
  logic [OW-1:0] disp_off;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_q;
  logic          rd_q;
  logic          slot_q;
  logic          de_q;
  logic [7:0]    shreg;

  assign h_act = h_count < 10'(H_ACTIVE);
  assign v_act = v_count < 10'(V_ACTIVE);
  assign disp_slot = h_act && v_act &&
                     (h_count[2:0] == 3'd0);
  assign grant = (state_q == IDLE) &&
                 host_req && !disp_slot;

  generate
    if (WORDS_PER_LINE == 80) begin : g_shift
      assign line_base = (OW'(v_count) << 6) +
                         (OW'(v_count) << 4);
    end else begin : g_mul
      assign line_base = OW'(v_count) *
                         OW'(WORDS_PER_LINE);
    end
  endgenerate

  assign disp_off = line_base + OW'(h_count[9:3]);

`ifdef FBA_PAGE_FLIP_EN
  logic pending;
  logic flip_evt;

  assign flip_evt = (h_count == 10'd0) &&
                    (v_count == 10'(V_ACTIVE));
  assign flip_done = flip_evt && pending;

  // A request seen in the flip cycle itself carries over to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page    <= 1'b0;
      pending <= 1'b0;
    end else if (flip_evt) begin
      pending <= flip_req;
      if (pending) begin
        page <= ~page;
      end
    end else if (flip_req) begin
      pending <= 1'b1;
    end
  end
`else
  logic unused_flip;

  assign page        = 1'b0;
  assign flip_done   = 1'b0;
  assign unused_flip = flip_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (grant) state_d = ACK;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus is combinational so a grant costs no extra cycle; idle cycles hold.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (!rst_n) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (disp_slot) begin
      mem_addr = {page, disp_off};
    end else if (grant) begin
      mem_addr  = host_addr;
      mem_we    = host_we;
      mem_wdata = host_wdata;
    end
  end

  assign host_ack   = (state_q == ACK);
  assign host_rdata = (host_ack && rd_q) ?
                      mem_rdata : rdata_q;
  assign pix_on     = pix_de && shreg[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      rdata_q <= host_rdata;
      if (grant) begin
        rd_q <= !host_we;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= 1'b0;
      de_q   <= 1'b0;
      pix_de <= 1'b0;
      shreg  <= '0;
    end else begin
      slot_q <= disp_slot;
      de_q   <= h_act && v_act;
      pix_de <= de_q;
      if (slot_q) begin
        shreg <= mem_rdata;
      end else begin
        shreg <= {shreg[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed vectors, queued expectations,
// decoupled negedge monitor, behavioural 1-cycle-latency RAM.
module tb_vga_fb_arbiter;

  localparam int AW = 17;

`ifdef FBA_PAGE_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  localparam int S_ACK  = 0;
  localparam int S_RD   = 1;
  localparam int S_ADDR = 2;
  localparam int S_WE   = 3;
  localparam int S_WD   = 4;
  localparam int S_PON  = 5;
  localparam int S_PDE  = 6;
  localparam int S_FD   = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    h;
  logic [9:0]    v;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;
  logic [7:0]    host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          pix_on;
  logic          pix_de;
  logic          flip_req;
  logic          flip_done;

  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  logic [7:0]    ram [0:(1<<AW)-1];

  typedef struct {
    int    cyc;
    int    sel;
    int    val;
    string nm;
  } exp_t;

  typedef struct {
    int         cyc;
    logic       rd;
    logic [7:0] data;
  } ack_t;

  exp_t expq[$];
  ack_t ackq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  vga_fb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .h_count    (h),
    .v_count    (v),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_on     (pix_on),
    .pix_de     (pix_de),
    .flip_req   (flip_req),
    .flip_done  (flip_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic int sample(int s);
    case (s)
      S_ACK:   return int'(host_ack);
      S_RD:    return int'(host_rdata);
      S_ADDR:  return int'(mem_addr);
      S_WE:    return int'(mem_we);
      S_WD:    return int'(mem_wdata);
      S_PON:   return int'(pix_on);
      S_PDE:   return int'(pix_de);
      S_FD:    return int'(flip_done);
      default: return -1;
    endcase
  endfunction

  // Monitor: compares queued expectations and every host_ack.
  always @(negedge clk) begin
    for (int i = expq.size() - 1; i >= 0; i--) begin
      if (expq[i].cyc <= cyc) begin
        int act;
        act = sample(expq[i].sel);
        total++;
        if (expq[i].cyc != cyc || act != expq[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%0h want=%0h@%0d",
                   expq[i].nm, cyc, act, expq[i].val, expq[i].cyc);
        end
        expq.delete(i);
      end
    end
    if (host_ack) begin
      total++;
      if (ackq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack cyc=%0d got=1 want=0", cyc);
      end else begin
        ack_t a;
        a = ackq.pop_front();
        if (a.cyc != cyc || (a.rd && host_rdata != a.data)) begin
          bad++;
          $display("FAIL ack cyc=%0d want_cyc=%0d rdata=%0h want=%0h",
                   cyc, a.cyc, host_rdata, a.data);
        end
      end
    end
  end

  task automatic expect_at(int c, int s, int val, string nm);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = val;
    e.nm  = nm;
    expq.push_back(e);
  endtask

  task automatic expect_ack(int c, logic rd, logic [7:0] d);
    ack_t a;
    a.cyc  = c;
    a.rd   = rd;
    a.data = d;
    ackq.push_back(a);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (h == 10'd799) begin
      h = 10'd0;
      v = (v == 10'd524) ? 10'd0 : v + 10'd1;
    end else begin
      h = h + 10'd1;
    end
  endtask

  task automatic jump(int hh, int vv);
    h = 10'(hh);
    v = 10'(vv);
  endtask

  task automatic preload(int a, logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = AW'(a);
    pl_data = d;
    tick();
    pl_we   = 1'b0;
  endtask

  task automatic host_issue(logic we, int a, logic [7:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = AW'(a);
    host_wdata = d;
  endtask

  task automatic host_wait_ack();
    int n;
    n = 0;
    while (!host_ack && n < 10) begin
      tick();
      n++;
    end
    if (!host_ack) begin
      total++;
      bad++;
      $display("FAIL ack_timeout cyc=%0d got=0 want=1", cyc);
    end
    host_req = 1'b0;
  endtask

  task automatic flip_pulse_at_v100();
    tick();
    jump(0, 100);
    flip_req = 1'b1;
    tick();
    flip_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    logic [7:0] w0;
    logic [7:0] w1;
    rst_n      = 1'b0;
    h          = 10'd790;
    v          = 10'd524;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    flip_req   = 1'b0;
    pl_we      = 1'b0;
    pl_addr    = '0;
    pl_data    = '0;
    w0         = 8'hA5;
    w1         = 8'h3C;

    preload(0, w0);
    preload(1, w1);
    preload(7, 8'h99);
    preload(38399, 8'h3C);

    expect_at(cyc, S_ACK, 0, "rst_ack");
    expect_at(cyc, S_ADDR, 0, "rst_addr");
    expect_at(cyc, S_PDE, 0, "rst_pde");
    expect_at(cyc, S_FD, 0, "rst_fdone");
    tick();
    rst_n = 1'b1;
    while (!(h == 10'd0 && v == 10'd0)) tick();

    // Frame start: words 0 and 1 scanned out, host collides with slot at h=8.
    c = cyc;
    expect_at(c, S_ADDR, 0, "slot0_addr");
    expect_at(c, S_WE, 0, "slot0_we");
    for (int i = 0; i < 8; i++) begin
      expect_at(c + 2 + i, S_PDE, 1, "pde_w0");
      expect_at(c + 2 + i, S_PON, int'(w0[7-i]), "pon_w0");
      expect_at(c + 10 + i, S_PDE, 1, "pde_w1");
      expect_at(c + 10 + i, S_PON, int'(w1[7-i]), "pon_w1");
    end
    repeat (8) tick();
    host_issue(1'b1, 'h12345, 8'h77);
    expect_at(cyc, S_ADDR, 1, "slot1_addr");
    expect_at(cyc, S_WE, 0, "slot1_we");
    expect_at(cyc + 1, S_ADDR, 'h12345, "grant_h9_addr");
    expect_at(cyc + 1, S_WE, 1, "grant_h9_we");
    expect_at(cyc + 1, S_WD, 'h77, "grant_h9_wd");
    expect_at(cyc + 2, S_WE, 0, "we_one_cycle");
    expect_ack(cyc + 2, 1'b0, 8'h00);
    host_wait_ack();
    repeat (10) tick();

    // Write at h=100, v=10: immediate grant, later slot undisturbed.
    jump(100, 10);
    c = cyc;
    host_issue(1'b1, 'h00321, 8'h5A);
    expect_at(c, S_WE, 1, "w100_we");
    expect_at(c, S_ADDR, 'h321, "w100_addr");
    expect_at(c, S_WD, 'h5A, "w100_wd");
    expect_at(c + 1, S_WE, 0, "w100_we_drop");
    expect_ack(c + 1, 1'b0, 8'h00);
    expect_at(c + 4, S_ADDR, 813, "slot_h104_addr");
    expect_at(c + 4, S_WE, 0, "slot_h104_we");
    host_wait_ack();
    repeat (4) tick();

    // Blanking reads, back to back.
    tick();
    jump(200, 500);
    c = cyc;
    host_issue(1'b0, 38399, 8'hEE);
    expect_at(c, S_ADDR, 38399, "rd_max_addr");
    expect_at(c, S_WE, 0, "rd_max_we");
    expect_at(c, S_WD, 'hEE, "rd_max_wd");
    expect_ack(c + 1, 1'b1, 8'h3C);
    for (int i = 2; i < 4; i++) begin
      expect_at(c + i, S_PDE, 0, "blank_pde");
      expect_at(c + i, S_PON, 0, "blank_pon");
    end
    host_wait_ack();
    tick();
    host_issue(1'b0, 'h12345, 8'hEE);
    expect_ack(cyc + 1, 1'b1, 8'h77);
    host_wait_ack();
    tick();

    // Reset in the ACK cycle of a read: dropped, outputs cleared at once.
    tick();
    jump(293, 20);
    c = cyc;
    host_issue(1'b0, 7, 8'hEE);
    tick();
    rst_n = 1'b0;
    expect_at(c + 1, S_ACK, 0, "rst_mid_ack");
    expect_at(c + 1, S_RD, 0, "rst_mid_rdata");
    expect_at(c + 1, S_ADDR, 0, "rst_mid_addr");
    expect_at(c + 1, S_WE, 0, "rst_mid_we");
    expect_at(c + 1, S_WD, 0, "rst_mid_wd");
    expect_at(c + 1, S_PDE, 0, "rst_mid_pde");
    expect_at(c + 3, S_ADDR, 0, "rst_slot_addr");
    expect_at(c + 3, S_PON, 0, "rst_slot_pon");
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    expect_at(c + 4, S_ACK, 0, "rel_no_ack");
    expect_at(c + 4, S_ADDR, 7, "rel_grant_addr");
    expect_ack(c + 5, 1'b1, 8'h99);
    host_wait_ack();
    tick();

    // Page flip sequence (tied off in the default build).
    flip_pulse_at_v100();
    jump(0, 480);
    expect_at(cyc, S_FD, FLIP ? 1 : 0, "flip1_done");
    expect_at(cyc + 1, S_FD, 0, "flip1_pulse");
    tick();
    tick();
    jump(0, 0);
    expect_at(cyc, S_ADDR, FLIP ? 'h10000 : 0, "flip1_page");
    expect_at(cyc, S_WE, 0, "flip1_we");
    flip_pulse_at_v100();
    jump(0, 480);
    expect_at(cyc, S_FD, FLIP ? 1 : 0, "flip2_done");
    tick();
    tick();
    jump(0, 0);
    expect_at(cyc, S_ADDR, 0, "flip2_page");
    tick();
    jump(0, 480);
    flip_req = 1'b1;
    expect_at(cyc, S_FD, 0, "flip3_same_cycle");
    tick();
    flip_req = 1'b0;
    tick();
    jump(0, 480);
    expect_at(cyc, S_FD, FLIP ? 1 : 0, "flip3_next_frame");
    tick();
    tick();
    jump(0, 0);
    expect_at(cyc, S_ADDR, FLIP ? 'h10000 : 0, "flip3_page");
    repeat (3) tick();

    if (expq.size() != 0 || ackq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover exp=%0d ack=%0d want=0",
               expq.size(), ackq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
